// File: rtl/matrix_mult_seq_mac.sv
// Sequential matrix multiplier: C = A x B for runtime size n (1..MAX_SIZE), computed
// one row-step per cycle over a row of MAX_SIZE MAC lanes. C holds until the next done.
module matrix_mult_seq_mac #(
  parameter int MAX_SIZE   = 10,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 64
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [31:0]                               matrix_size,
  input  logic                                      signed_mode,
  input  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0]   A,
  input  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0]   B,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      size_err,
  output logic [MAX_SIZE*MAX_SIZE*ACC_WIDTH-1:0]    C,
  output logic [1:0]                                dbg_state
);

  localparam int NE  = MAX_SIZE * MAX_SIZE;
  localparam int OPW = NE * DATA_WIDTH;
  localparam int CW  = NE * ACC_WIDTH;
  localparam int IW  = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
  localparam int PW  = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [OPW-1:0]        a_q, a_d, b_q, b_d;
  logic [IW-1:0]         nm1_q, nm1_d;
  logic                  sgn_q, sgn_d;
  logic [IW-1:0]         i_q, i_d, k_q, k_d;
  logic [CW-1:0]         acc_q, acc_d;
  logic [CW-1:0]         c_q, c_d;
  logic                  size_err_q, size_err_d;

  logic [DATA_WIDTH-1:0] a_el, b_el;
  logic [PW-1:0]         ea, eb, prod;
  logic [ACC_WIDTH-1:0]  term [MAX_SIZE];
  logic                  size_ok;

  // Per-lane product for the current step: A[i][k] times B[k][j], extended to
  // 2*DATA_WIDTH, multiplied modulo 2^(2*DATA_WIDTH), then resized to ACC_WIDTH.
  always_comb begin
    a_el = '0;
    for (int r = 0; r < MAX_SIZE; r++) begin
      for (int c = 0; c < MAX_SIZE; c++) begin
        if (IW'(r) == i_q && IW'(c) == k_q) a_el = a_q[(r*MAX_SIZE+c)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ea = {{DATA_WIDTH{sgn_q & a_el[DATA_WIDTH-1]}}, a_el};
    b_el = '0;
    eb   = '0;
    prod = '0;
    for (int j = 0; j < MAX_SIZE; j++) begin
      b_el = '0;
      for (int r = 0; r < MAX_SIZE; r++) begin
        if (IW'(r) == k_q) b_el = b_q[(r*MAX_SIZE+j)*DATA_WIDTH +: DATA_WIDTH];
      end
      eb      = {{DATA_WIDTH{sgn_q & b_el[DATA_WIDTH-1]}}, b_el};
      prod    = ea * eb;
      term[j] = sgn_q ? ACC_WIDTH'($signed(prod)) : ACC_WIDTH'(prod);
    end
  end

  assign size_ok = (matrix_size != 32'd0) && (matrix_size <= 32'(MAX_SIZE));

  // Handshake: start is a level sampled each edge. In IDLE/DONE it launches a job
  // (legal n) or yields a one-cycle size_err (illegal n); in COMPUTE it is ignored.
  // done is a one-cycle pulse in the DONE state; busy is high exactly in COMPUTE.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    nm1_d      = nm1_q;
    sgn_d      = sgn_q;
    i_d        = i_q;
    k_d        = k_q;
    acc_d      = acc_q;
    c_d        = c_q;
    size_err_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (size_ok) begin
            a_d     = A;
            b_d     = B;
            nm1_d   = IW'(matrix_size - 32'd1);
            sgn_d   = signed_mode;
            acc_d   = '0;
            i_d     = '0;
            k_d     = '0;
            state_d = S_COMPUTE;
          end else begin
            size_err_d = 1'b1;
            state_d    = S_IDLE;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_COMPUTE: begin
        for (int r = 0; r < MAX_SIZE; r++) begin
          for (int j = 0; j < MAX_SIZE; j++) begin
            if (IW'(r) == i_q && IW'(j) <= nm1_q) begin
              acc_d[(r*MAX_SIZE+j)*ACC_WIDTH +: ACC_WIDTH] =
                acc_q[(r*MAX_SIZE+j)*ACC_WIDTH +: ACC_WIDTH] + term[j];
            end
          end
        end
        if (k_q == nm1_q) begin
          k_d = '0;
          if (i_q == nm1_q) begin
            i_d     = '0;
            c_d     = acc_d;
            state_d = S_DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      nm1_q      <= '0;
      sgn_q      <= 1'b0;
      i_q        <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      c_q        <= '0;
      size_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      nm1_q      <= nm1_d;
      sgn_q      <= sgn_d;
      i_q        <= i_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      c_q        <= c_d;
      size_err_q <= size_err_d;
    end
  end

  assign busy      = (state_q == S_COMPUTE);
  assign done      = (state_q == S_DONE);
  assign size_err  = size_err_q;
  assign C         = c_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_matrix_mult_seq_mac.sv
// Directed bench for matrix_mult_seq_mac: 64-bit accumulator instance plus a
// 32-bit accumulator instance for the wrap-around case.
module tb_matrix_mult_seq_mac;

  localparam int MS  = 10;
  localparam int DW  = 32;
  localparam int OPW = MS * MS * DW;

  logic              clk;
  logic              rst;
  logic              start, start32;
  logic [31:0]       matrix_size;
  logic              signed_mode;
  logic [OPW-1:0]    a_in, b_in;
  logic              busy, done, size_err;
  logic [MS*MS*64-1:0] c_out;
  logic [1:0]        dbg_state;
  logic              busy32, done32, size_err32;
  logic [MS*MS*32-1:0] c32;
  logic [1:0]        dbg_state32;

  int          checks   = 0;
  int          failures = 0;
  logic        use32    = 1'b0;
  logic [63:0] exp_q[$];
  logic        cur_done, cur_busy, cur_err;

  assign cur_done = use32 ? done32 : done;
  assign cur_busy = use32 ? busy32 : busy;
  assign cur_err  = use32 ? size_err32 : size_err;

  matrix_mult_seq_mac #(.MAX_SIZE(MS), .DATA_WIDTH(DW), .ACC_WIDTH(64)) u_dut (
    .clk(clk), .rst(rst), .start(start), .matrix_size(matrix_size),
    .signed_mode(signed_mode), .A(a_in), .B(b_in), .busy(busy), .done(done),
    .size_err(size_err), .C(c_out), .dbg_state(dbg_state)
  );

  matrix_mult_seq_mac #(.MAX_SIZE(MS), .DATA_WIDTH(DW), .ACC_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .matrix_size(matrix_size),
    .signed_mode(signed_mode), .A(a_in), .B(b_in), .busy(busy32), .done(done32),
    .size_err(size_err32), .C(c32), .dbg_state(dbg_state32)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver and checking tasks
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input int r, input int c, input logic [31:0] v);
    a_in[(r*MS+c)*DW +: DW] = v;
  endtask

  task automatic set_b(input int r, input int c, input logic [31:0] v);
    b_in[(r*MS+c)*DW +: DW] = v;
  endtask

  function automatic logic [63:0] c_el(input int r, input int c);
    if (use32) return 64'(c32[(r*MS+c)*32 +: 32]);
    return c_out[(r*MS+c)*64 +: 64];
  endfunction

  task automatic exp_clear();
    exp_q.delete();
    for (int i = 0; i < MS*MS; i++) exp_q.push_back(64'd0);
  endtask

  task automatic check_c(input string tag);
    logic [63:0] e;
    for (int r = 0; r < MS; r++) begin
      for (int c = 0; c < MS; c++) begin
        e = exp_q.pop_front();
        chk($sformatf("%s_c%0d_%0d", tag, r, c), c_el(r, c), e);
      end
    end
  endtask

  task automatic drive_start(input int n, input logic sgn);
    matrix_size = 32'(n);
    signed_mode = sgn;
    if (use32) start32 = 1'b1;
    else       start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    start32 = 1'b0;
  endtask

  // m0 = number of post-start cycles already consumed (and checked busy) by the caller
  task automatic wait_done(input string tag, input int n, input int m0);
    int m, bc;
    bit got;
    m = m0; bc = m0; got = 1'b0;
    repeat (n*n + 20) begin
      @(negedge clk);
      if (cur_done) begin
        got = 1'b1;
        break;
      end
      if (cur_busy) bc++;
      m++;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_latency"}, 64'(m), 64'(n*n));
    chk({tag, "_busy_cycles"}, 64'(bc), 64'(n*n));
    chk({tag, "_busy_at_done"}, 64'(cur_busy), 64'd0);
    chk({tag, "_err_at_done"}, 64'(cur_err), 64'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; start32 = 1'b0; signed_mode = 1'b0;
    matrix_size = 32'd0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(size_err), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_busy32", 64'(busy32), 64'd0);
    exp_clear(); check_c("rst");
    use32 = 1'b1; exp_clear(); check_c("rst32"); use32 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: n=2 unsigned, surrounding elements all ones
    a_in = '1; b_in = '1;
    set_a(0, 0, 1); set_a(0, 1, 2); set_a(1, 0, 3); set_a(1, 1, 4);
    set_b(0, 0, 5); set_b(0, 1, 6); set_b(1, 0, 7); set_b(1, 1, 8);
    drive_start(2, 1'b0);
    wait_done("t1", 2, 0);
    exp_clear();
    exp_q[0] = 64'd19; exp_q[1] = 64'd22; exp_q[MS] = 64'd43; exp_q[MS+1] = 64'd50;
    check_c("t1");
    @(negedge clk);
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_back_idle", 64'(dbg_state), 64'd0);

    // 2: n=10 identity x B, then back-to-back start in the DONE cycle with zeros
    a_in = '0; b_in = '0;
    for (int r = 0; r < MS; r++) begin
      set_a(r, r, 1);
      for (int c = 0; c < MS; c++) set_b(r, c, 32'(r*10 + c));
    end
    drive_start(10, 1'b0);
    wait_done("t2a", 10, 0);
    exp_clear();
    for (int i = 0; i < MS*MS; i++) exp_q[i] = 64'(i);
    check_c("t2a");
    a_in = '0; b_in = '0;
    drive_start(10, 1'b0);
    wait_done("t2b", 10, 0);
    exp_clear(); check_c("t2b");

    // 3: n=1 signed vs unsigned extension
    set_a(0, 0, 32'hFFFF_FFFD); set_b(0, 0, 32'd4);
    drive_start(1, 1'b1);
    wait_done("t3s", 1, 0);
    exp_clear(); exp_q[0] = 64'hFFFF_FFFF_FFFF_FFF4; check_c("t3s");
    drive_start(1, 1'b0);
    wait_done("t3u", 1, 0);
    exp_clear(); exp_q[0] = 64'h0000_0003_FFFF_FFF4; check_c("t3u");
    @(negedge clk);

    // 4: illegal sizes 0 and 11
    drive_start(0, 1'b0);
    @(negedge clk);
    chk("t4_0_err", 64'(size_err), 64'd1);
    chk("t4_0_busy", 64'(busy), 64'd0);
    chk("t4_0_done", 64'(done), 64'd0);
    @(negedge clk);
    chk("t4_0_err_pulse", 64'(size_err), 64'd0);
    chk("t4_0_busy2", 64'(busy), 64'd0);
    drive_start(11, 1'b0);
    @(negedge clk);
    chk("t4_11_err", 64'(size_err), 64'd1);
    chk("t4_11_busy", 64'(busy), 64'd0);
    chk("t4_11_done", 64'(done), 64'd0);
    @(negedge clk);
    chk("t4_11_err_pulse", 64'(size_err), 64'd0);
    chk("t4_11_state", 64'(dbg_state), 64'd0);
    exp_clear(); exp_q[0] = 64'h0000_0003_FFFF_FFF4; check_c("t4_keep");

    // 5: n=3, ignored second start with changed operands, then reset mid-job
    for (int r = 0; r < MS; r++) begin
      for (int c = 0; c < MS; c++) begin
        set_a(r, c, 32'd7); set_b(r, c, 32'd7);
      end
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        set_a(r, c, 32'(r*3 + c + 1));
        set_b(r, c, 32'd0);
      end
    end
    set_b(0, 0, 1); set_b(0, 1, 1); set_b(1, 1, 1); set_b(1, 2, 1); set_b(2, 0, 1); set_b(2, 2, 1);
    drive_start(3, 1'b0);
    @(negedge clk);
    chk("t5_busy_c0", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t5_busy_c1", 64'(busy), 64'd1);
    a_in = '1; b_in = '1; matrix_size = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5", 3, 2);
    exp_clear();
    exp_q[0] = 64'd4;       exp_q[1] = 64'd3;       exp_q[2] = 64'd5;
    exp_q[MS] = 64'd10;     exp_q[MS+1] = 64'd9;    exp_q[MS+2] = 64'd11;
    exp_q[2*MS] = 64'd16;   exp_q[2*MS+1] = 64'd15; exp_q[2*MS+2] = 64'd17;
    check_c("t5");
    @(negedge clk);
    drive_start(3, 1'b0);
    repeat (5) @(negedge clk);
    chk("t5_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    chk("t5_rst_state", 64'(dbg_state), 64'd0);
    exp_clear(); check_c("t5_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("t5_no_done_after_abort", 64'(seen), 64'd0);

    // 6: 32-bit accumulator build, truncation and wrap
    use32 = 1'b1;
    a_in = '1; b_in = '1;
    drive_start(2, 1'b0);
    wait_done("t6pre", 2, 0);
    exp_clear();
    exp_q[0] = 64'd2; exp_q[1] = 64'd2; exp_q[MS] = 64'd2; exp_q[MS+1] = 64'd2;
    check_c("t6pre");
    for (int r = 0; r < MS; r++) begin
      for (int c = 0; c < MS; c++) begin
        set_a(r, c, 32'h8000_0000); set_b(r, c, 32'h8000_0000);
      end
    end
    drive_start(2, 1'b0);
    wait_done("t6", 2, 0);
    exp_clear(); check_c("t6");
    use32 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_mult_seq_mac.md
Name: matrix_mult_seq_mac

Overview:
Sequential, parametrised successor to the flat combinational matrix multiplier.
- Captures flattened square matrices A and B on a start handshake and computes C = A x B over n*n cycles.
- Uses a row of MAX_SIZE parallel MAC lanes, with runtime size n, signed/unsigned mode and a configurable accumulator width.
- Sits between the host-side operand registers and the result readback logic; C is held stable until the next completed job.

Parameters:
- MAX_SIZE, 10, maximum matrix dimension; also the number of MAC lanes.
- DATA_WIDTH, 32, width of each A/B element.
- ACC_WIDTH, 64, width of each C element and of each accumulator. Legal range is DATA_WIDTH <= ACC_WIDTH <= 2*DATA_WIDTH+8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled on clk.
- matrix_size  in  32  n, sampled with start; legal range 1..MAX_SIZE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- A  in  MAX_SIZE*MAX_SIZE*DATA_WIDTH  row-major flattened; element (r,c) is at bit offset (r*MAX_SIZE+c)*DATA_WIDTH.
- B  in  MAX_SIZE*MAX_SIZE*DATA_WIDTH  same layout as A.
- busy  out  1  high while a job is in progress.
- done  out  1  one-cycle pulse when C has been updated.
- size_err  out  1  one-cycle pulse when a job is rejected for an illegal size.
- C  out  MAX_SIZE*MAX_SIZE*ACC_WIDTH  row-major flattened; element (r,c) is at bit offset (r*MAX_SIZE+c)*ACC_WIDTH.

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, size_err=0; C=0; accumulators and indices cleared. Assertion mid-job aborts the job and no done is produced.
- States: IDLE, COMPUTE, DONE.
- IDLE or DONE with start=1 and 1<=n<=MAX_SIZE:
  - Capture A, B, n and signed_mode into internal registers.
  - Clear all accumulators; set i=0, k=0.
  - Go to COMPUTE. busy=1 from the next cycle.
- IDLE or DONE with start=1 and n==0 or n>MAX_SIZE:
  - size_err=1 for the following cycle; state goes to IDLE.
  - C unchanged; busy stays 0.
- DONE with start=0: go to IDLE.
- COMPUTE, one step per cycle:
  - For every lane j<n: acc[i][j] += ext(A[i][k]) * ext(B[k][j]). Lanes j>=n are held at 0.
  - k increments; when k==n-1, k wraps to 0 and i increments.
  - After the step with i==n-1 and k==n-1: copy all accumulators to C atomically (elements with r>=n or c>=n are 0), set done=1, busy=0, go to DONE.
- start while in COMPUTE is ignored. Operand inputs may change freely during COMPUTE because they were captured.
- Latency: start sampled at edge T0 → steps at edges T1..T(n*n) → done high during the cycle after edge T(n*n), i.e. n*n cycles after the start edge. busy is high for exactly n*n cycles.
- Back-to-back: start accepted in the DONE cycle gives zero idle gap.
- Arithmetic:
  - ext() zero-extends (signed_mode=0) or sign-extends (signed_mode=1) each operand to 2*DATA_WIDTH.
  - The full 2*DATA_WIDTH product is truncated or extended to ACC_WIDTH using the same signedness.
  - Accumulation wraps modulo 2^ACC_WIDTH; no saturation and no overflow flag.
- C changes only on the done edge or on reset. Between jobs C holds the last result.
- done and size_err are never high in the same cycle.

Test Plan:
1. n=2, unsigned, A=[[1,2],[3,4]], B=[[5,6],[7,8]], all other elements 0xFFFFFFFF → done exactly 4 cycles after the start edge, C=[[19,22],[43,50]], all other C elements 0, busy high for 4 cycles.
2. n=10, A=identity, B(r,c)=r*10+c → done 100 cycles after start, C==B zero-extended to 64 bits; then assert start in the DONE cycle with A=B=0 → second done 100 cycles later, C all 0.
3. n=1, A(0,0)=0xFFFFFFFD, B(0,0)=4:
   - signed_mode=1 → C(0,0)=0xFFFFFFFFFFFFFFF4.
   - signed_mode=0 → C(0,0)=0x00000003FFFFFFF4.
4. matrix_size=0, then matrix_size=11 → each gives one size_err pulse, busy=0, done=0, C retains the previous result.
5. Start an n=3 job; pulse start again and change A/B at cycle 2 → second start ignored, result matches the originally captured operands; assert rst at cycle 5 of a new job → busy=0, C=0 immediately, no done.
6. ACC_WIDTH=32 build, n=2, unsigned, all elements 0x80000000 → C elements wrap to 0x00000000; done timing unchanged (4 cycles).
